// File: rtl/arb_request_agent_if.sv
// Job-offer and arbiter request/grant signals for arb_request_agent.
// The slave modport is the agent side and the master modport is the job source / arbiter side.
interface arb_request_agent_if;
    logic       job_valid;
    logic [1:0] job_chan;
    logic [3:0] job_len;
    logic       job_ready;
    logic       request1;
    logic       request2;
    logic       request3;
    logic       request4;
    logic [3:0] grant_i;

    modport master (
        output job_valid, job_chan, job_len, grant_i,
        input  job_ready, request1, request2, request3, request4
    );

    modport slave (
        input  job_valid, job_chan, job_len, grant_i,
        output job_ready, request1, request2, request3, request4
    );
endinterface

// File: rtl/arb_request_agent.sv
// Four-channel arbiter request agent: per-channel IDLE/REQ/XFER/REL FSMs, completion counter,
// protocol error flags. Optional starvation detection under macro ARB_AGENT_STARVE_DETECT_EN.
module arb_request_agent (
    input  logic                clock,
    input  logic                reset,
    arb_request_agent_if.slave  bus,
    output logic [3:0]          done,
    output logic                busy,
    output logic [15:0]         served_count,
    output logic                err_multi,
    output logic                err_spurious,
    output logic [3:0]          starve
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } ch_state_t;

    ch_state_t   state_r         [4];
    ch_state_t   state_nxt_s     [4];
    logic [3:0]  remaining_r     [4];
    logic [3:0]  remaining_nxt_s [4];
    logic [3:0]  finish_s;
    logic [3:0]  request_nxt_s;
    logic [3:0]  spurious_vec_s;
    logic        busy_nxt_s;
    logic        multi_s;
    logic [16:0] served_sum_s;
    logic [15:0] served_nxt_s;

    logic [3:0]  request_r;
    logic [3:0]  done_r;
    logic        busy_r;
    logic [15:0] served_r;
    logic        err_multi_r;
    logic        err_spurious_r;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    assign bus.job_ready = (state_r[bus.job_chan] == ST_IDLE);

    // Per-channel next state, remaining-beat count and completion detection
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_nxt_s[n]     = state_r[n];
            remaining_nxt_s[n] = remaining_r[n];
            finish_s[n]        = 1'b0;
            case (state_r[n])
                ST_IDLE: begin
                    if (bus.job_valid && (bus.job_chan == 2'(n))) begin
                        state_nxt_s[n]     = ST_REQ;
                        remaining_nxt_s[n] = bus.job_len;
                    end else begin
                        state_nxt_s[n] = ST_IDLE;
                    end
                end
                ST_REQ, ST_XFER: begin
                    if (bus.grant_i[n]) begin
                        if (remaining_r[n] == 4'd0) begin
                            state_nxt_s[n] = ST_REL;
                            finish_s[n]    = 1'b1;
                        end else begin
                            state_nxt_s[n]     = ST_XFER;
                            remaining_nxt_s[n] = remaining_r[n] - 4'd1;
                        end
                    end else begin
                        // a lost grant parks the job in REQ with its remaining count intact
                        state_nxt_s[n] = ST_REQ;
                    end
                end
                ST_REL:  state_nxt_s[n] = ST_IDLE;
                default: state_nxt_s[n] = ST_IDLE;
            endcase
        end
    end

    // Registered-output next values, error detection and saturating completion count
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int n = 0; n < 4; n++) begin
            request_nxt_s[n]  = (state_nxt_s[n] == ST_REQ) || (state_nxt_s[n] == ST_XFER);
            spurious_vec_s[n] = bus.grant_i[n] &&
                                ((state_r[n] == ST_IDLE) || (state_r[n] == ST_REL));
            busy_nxt_s        = busy_nxt_s | (state_nxt_s[n] != ST_IDLE);
        end
        multi_s      = (popcount4(bus.grant_i) > 3'd1);
        served_sum_s = {1'b0, served_r} + {14'd0, popcount4(finish_s)};
        if (served_sum_s[16]) begin
            served_nxt_s = 16'hFFFF;
        end else begin
            served_nxt_s = served_sum_s[15:0];
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_r[n]     <= ST_IDLE;
                remaining_r[n] <= 4'd0;
            end
            request_r      <= 4'b0000;
            done_r         <= 4'b0000;
            busy_r         <= 1'b0;
            served_r       <= 16'd0;
            err_multi_r    <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_r[n]     <= state_nxt_s[n];
                remaining_r[n] <= remaining_nxt_s[n];
            end
            request_r      <= request_nxt_s;
            done_r         <= finish_s;
            busy_r         <= busy_nxt_s;
            served_r       <= served_nxt_s;
            err_multi_r    <= err_multi_r | multi_s;
            err_spurious_r <= err_spurious_r | (|spurious_vec_s);
        end
    end

    assign bus.request1  = request_r[0];
    assign bus.request2  = request_r[1];
    assign bus.request3  = request_r[2];
    assign bus.request4  = request_r[3];
    assign done          = done_r;
    assign busy          = busy_r;
    assign served_count  = served_r;
    assign err_multi     = err_multi_r;
    assign err_spurious  = err_spurious_r;

`ifdef ARB_AGENT_STARVE_DETECT_EN
    logic [7:0] wait_r     [4];
    logic [7:0] wait_nxt_s [4];
    logic [3:0] starve_r;

    // Wait counters: cleared on job entry and on beats, saturating count of beat-free cycles
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            wait_nxt_s[n] = wait_r[n];
            if ((state_r[n] == ST_IDLE) && (state_nxt_s[n] == ST_REQ)) begin
                wait_nxt_s[n] = 8'd0;
            end else if ((state_r[n] == ST_REQ) || (state_r[n] == ST_XFER)) begin
                if (bus.grant_i[n]) begin
                    wait_nxt_s[n] = 8'd0;
                end else if (wait_r[n] != 8'hFF) begin
                    wait_nxt_s[n] = wait_r[n] + 8'd1;
                end else begin
                    wait_nxt_s[n] = wait_r[n];
                end
            end else begin
                wait_nxt_s[n] = wait_r[n];
            end
        end
    end

    // Wait counter registers and sticky starvation flags
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                wait_r[n] <= 8'd0;
            end
            starve_r <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                wait_r[n]   <= wait_nxt_s[n];
                starve_r[n] <= starve_r[n] | (wait_nxt_s[n] == 8'hFF);
            end
        end
    end

    assign starve = starve_r;
`else
    assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_arb_request_agent.sv
// Self-checking bench for arb_request_agent: directed scenarios plus random traffic,
// every cycle compared against a beat-counting reference model.
module tb_arb_request_agent;
    logic        clock;
    logic        reset;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] served_count;
    logic        err_multi;
    logic        err_spurious;
    logic [3:0]  starve;

    arb_request_agent_if bus ();

    arb_request_agent dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .done         (done),
        .busy         (busy),
        .served_count (served_count),
        .err_multi    (err_multi),
        .err_spurious (err_spurious),
        .starve       (starve)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit ready_chk_en = 1'b0;

    // Reference model: a job is "active" while it still owes beats, then one cool-down cycle.
    bit [3:0] m_active;
    bit [3:0] m_cool;
    int       m_left [4];
    int       m_wait [4];
    bit [3:0] m_done;
    int       m_served;
    bit       m_multi;
    bit       m_spur;
    bit [3:0] m_starve;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit acc_ok;
        int completions;
        if (reset) begin
            m_active = 4'b0; m_cool = 4'b0; m_done = 4'b0; m_served = 0;
            m_multi = 1'b0; m_spur = 1'b0; m_starve = 4'b0;
            for (int n = 0; n < 4; n++) begin m_left[n] = 0; m_wait[n] = 0; end
        end else begin
            acc_ok = bus.job_valid && !m_active[bus.job_chan] && !m_cool[bus.job_chan];
            if ($countones(bus.grant_i) > 1) m_multi = 1'b1;
            completions = 0;
            m_done = 4'b0;
            for (int n = 0; n < 4; n++) begin
                if (bus.grant_i[n] && !m_active[n]) m_spur = 1'b1;
                if (m_active[n]) begin
                    if (bus.grant_i[n]) begin
                        m_left[n]--;
                        m_wait[n] = 0;
                        if (m_left[n] == 0) begin
                            m_active[n] = 1'b0; m_cool[n] = 1'b1; m_done[n] = 1'b1;
                            completions++;
                        end
                    end else begin
                        if (m_wait[n] < 255) m_wait[n]++;
`ifdef ARB_AGENT_STARVE_DETECT_EN
                        if (m_wait[n] == 255) m_starve[n] = 1'b1;
`endif
                    end
                end else if (m_cool[n]) begin
                    m_cool[n] = 1'b0;
                end else if (acc_ok && (int'(bus.job_chan) == n)) begin
                    m_active[n] = 1'b1;
                    m_left[n]   = int'(bus.job_len) + 1;
                    m_wait[n]   = 0;
                end
            end
            m_served = (m_served + completions > 65535) ? 65535 : m_served + completions;
        end
    endtask

    task automatic check_outputs();
        chk("request", {bus.request4, bus.request3, bus.request2, bus.request1}, m_active);
        chk("done", done, m_done);
        chk("busy", busy, |(m_active | m_cool));
        chk("served_count", served_count, m_served);
        chk("err_multi", err_multi, m_multi);
        chk("err_spurious", err_spurious, m_spur);
        chk("starve", starve, m_starve);
    endtask

    task automatic cycle();
        #1;
        if (ready_chk_en)
            chk("job_ready", bus.job_ready,
                !(m_active[bus.job_chan] || m_cool[bus.job_chan]));
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit [1:0] ch, input bit [3:0] len, input bit [3:0] g);
        bus.job_valid = v; bus.job_chan = ch; bus.job_len = len; bus.grant_i = g;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 4'b0000);
        cycle();
        cycle();
        reset = 1'b0;
        ready_chk_en = 1'b1;
    endtask

    initial begin
        int cnt_req;
        int cnt_done;
        int budget;
        bit [3:0] g_sched [7];
        reset = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 4'b0000);

        // Reset state
        do_reset();
        chk("rst_served", served_count, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", bus.job_ready, 1'b1);

        // ch0 len=0, grant two cycles after request1 rises
        cnt_req = 0; cnt_done = 0;
        drive(1'b1, 2'd0, 4'd0, 4'b0000);
        cycle();
        cnt_req += bus.request1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 4'd0, (k == 2) ? 4'b0001 : 4'b0000);
            cycle();
            cnt_req += bus.request1;
            cnt_done += done[0];
        end
        chk("d1_req_cycles", cnt_req, 3);
        chk("d1_done_pulses", cnt_done, 1);
        chk("d1_served", served_count, 16'd1);

        // ch2 len=3, grant held 2 / dropped 3 / held 2
        g_sched = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        cnt_req = 0; cnt_done = 0;
        drive(1'b1, 2'd2, 4'd3, 4'b0000);
        cycle();
        for (int k = 0; k < 7; k++) begin
            chk("d2_req3_high", bus.request3, 1'b1);
            drive(1'b0, 2'd0, 4'd0, g_sched[k]);
            cycle();
            cnt_done += done[2];
        end
        chk("d2_req3_rel", bus.request3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'd0, 4'd0, 4'b0000);
            cycle();
            cnt_done += done[2];
        end
        chk("d2_done_pulses", cnt_done, 1);
        chk("d2_no_errors", {err_multi, err_spurious}, 2'b00);

        // All four channels, len=1, rotated one-hot grants
        do_reset();
        cnt_done = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 2'(c), 4'd1, 4'b0000);
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 2'd0, 4'd0, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
            cycle();
            cnt_done += $countones(done);
        end
        chk("d3_done_pulses", cnt_done, 4);
        chk("d3_served", served_count, 16'd4);
        chk("d3_busy_low", busy, 1'b0);

        // Protocol errors
        drive(1'b0, 2'd0, 4'd0, 4'b0011);
        cycle();
        chk("d4_err_multi", err_multi, 1'b1);
        for (int k = 0; k < 3; k++) begin drive(1'b0, 2'd0, 4'd0, 4'b0000); cycle(); end
        chk("d4_err_multi_held", err_multi, 1'b1);
        do_reset();
        chk("d4_err_multi_clr", err_multi, 1'b0);
        drive(1'b0, 2'd0, 4'd0, 4'b1000);
        cycle();
        chk("d4_err_spurious", err_spurious, 1'b1);
        chk("d4_err_multi_still0", err_multi, 1'b0);

        // Starvation on ch1
        do_reset();
        drive(1'b1, 2'd1, 4'd0, 4'b0000);
        cycle();
        for (int k = 0; k < 260; k++) begin drive(1'b0, 2'd0, 4'd0, 4'b0000); cycle(); end
`ifdef ARB_AGENT_STARVE_DETECT_EN
        chk("d5_starve", starve, 4'b0010);
`else
        chk("d5_starve", starve, 4'b0000);
`endif

        // Random traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  (r < 6) ? (4'b0001 << $urandom_range(0, 3)) : ((r < 9) ? 4'b0000 : 4'($urandom)));
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        // Saturate served_count with back-to-back len=0 jobs on ch0..ch2
        do_reset();
        budget = 0;
        while (m_served < 65535 && budget < 70000) begin
            drive(1'b1, 2'(budget % 3), 4'd0, 4'b0111);
            cycle();
            budget++;
        end
        chk("d6_fill_budget", (budget < 70000), 1'b1);
        for (int k = 0; k < 3; k++) begin drive(1'b0, 2'd0, 4'd0, 4'b0111); cycle(); end
        chk("d6_served_sat", served_count, 16'hFFFF);
        drive(1'b1, 2'd1, 4'd0, 4'b0000);
        cycle();
        drive(1'b0, 2'd0, 4'd0, 4'b0010);
        cycle();
        chk("d6_done_extra", done, 4'b0010);
        chk("d6_served_hold", served_count, 16'hFFFF);

        // Reset mid-XFER on ch0
        drive(1'b1, 2'd0, 4'd3, 4'b0000);
        cycle();
        drive(1'b0, 2'd0, 4'd0, 4'b0001);
        cycle();
        cycle();
        reset = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 4'b0000);
        cycle();
        reset = 1'b0;
        chk("d7_served_rst", served_count, 16'd0);
        chk("d7_req1_rst", bus.request1, 1'b0);
        cnt_done = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 4'd0, 4'b0000);
            cycle();
            cnt_done += $countones(done);
        end
        chk("d7_no_done", cnt_done, 0);
        chk("d7_errs_rst", {err_multi, err_spurious}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_request_agent.md
ARB_REQUEST_AGENT -- requirements
Module: arb_request_agent

Interface
REQ-001 The block SHALL have ports: clock  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 job_valid  input  1  a job is offered this cycle.
REQ-004 job_chan  input  2  target channel of the offered job (0..3 map to request1..request4).
REQ-005 job_len  input  4  job length minus one: the job takes job_len+1 granted beats.
REQ-006 job_ready  output  1  combinational; high when channel job_chan is in IDLE.
REQ-007 request1, request2, request3, request4  output  1 each  registered arbiter request lines.
REQ-008 grant_i  input  4  arbiter grant vector; bit n answers request(n+1).
REQ-009 done  output  4  one-cycle pulse per channel on job completion.
REQ-010 busy  output  1  OR of all channels not in IDLE.
REQ-011 served_count  output  16  completed-job counter, saturating at 16'hFFFF.
REQ-012 err_multi, err_spurious  output  1 each  sticky protocol-error flags.
REQ-013 starve  output  4  sticky per-channel starvation flags (see Configuration).

Function
REQ-014 Each channel SHALL run an independent FSM: IDLE, REQ, XFER, REL.
REQ-015 A job SHALL be accepted on an edge with job_valid=1 and job_ready=1: channel loads remaining=job_len, moves IDLE->REQ; the request line is high from the next cycle (1-cycle latency).
REQ-016 job_valid with job_ready=0 SHALL be ignored; nothing is queued.
REQ-017 Request SHALL be high in REQ and XFER, low in IDLE and REL.
REQ-018 Each edge in REQ or XFER with the channel's grant bit high SHALL be one beat; REQ moves to XFER on the first beat.
REQ-019 On the beat where remaining=0, the channel SHALL move to REL and pulse its done bit in the following cycle; otherwise remaining decrements.
REQ-020 A beat-free edge in XFER (grant dropped mid-job) SHALL return the channel to REQ, keeping remaining unchanged (resume, no restart).
REQ-021 REL SHALL last exactly one cycle, then IDLE; back-to-back jobs on one channel therefore have at least one request-low cycle between them.
REQ-022 job_len=0 SHALL complete after exactly one beat: request high for N+1 cycles when the grant arrives N cycles after the request rises.
REQ-023 served_count SHALL add the number of channels completing on that edge, saturating at 16'hFFFF (no wrap).
REQ-024 err_multi SHALL set on any edge where grant_i has more than one bit high.
REQ-025 err_spurious SHALL set on any edge where a grant bit is high for a channel in IDLE or REL.
REQ-026 Beats SHALL still be counted per channel when err_multi is raised; errors never alter FSM behaviour.

Reset
REQ-027 Reset SHALL put all channels in IDLE, remaining=0, and drive request1..4=0, done=0, busy=0, served_count=0, err_multi=0, err_spurious=0, starve=0.
REQ-028 Reset mid-job SHALL abandon the job without a done pulse; request drops the cycle after reset is sampled.
REQ-029 Error and starve flags SHALL clear only on reset.

Configuration
REQ-030 Macro ARB_AGENT_STARVE_DETECT_EN defined: each channel SHALL have an 8-bit wait counter, cleared on entering REQ and on any beat, incremented each cycle in REQ or XFER without a beat; reaching 255 sets the channel's starve bit (sticky); the counter saturates.
REQ-031 Macro undefined: no wait counters SHALL be built and starve SHALL be tied to 4'b0000.

Verification
REQ-032 Reset, job ch0 len=0, grant_i=4'b0001 two cycles after request1 rises -> request1 high 3 cycles, done=4'b0001 once, served_count=1.
REQ-033 Job ch2 len=3, grant held 2 cycles, dropped 3, held 2 -> exactly 4 beats counted, request3 stays high throughout, one done pulse, no errors.
REQ-034 Jobs on all 4 channels, grants rotated one-hot one beat each, len=1 -> 4 done pulses, served_count=4, busy low after last REL.
REQ-035 grant_i=4'b0011 for one cycle -> err_multi=1 and held until reset; grant_i=4'b1000 with ch3 IDLE -> err_spurious=1.
REQ-036 With macro defined, job ch1 and no grant for 255 cycles -> starve=4'b0010; without macro -> starve stays 0.
REQ-037 Reset asserted mid-XFER on ch0 with served_count=16'hFFFF preloaded by completions -> all outputs return to reset values, no done pulse; a further completion before reset holds served_count at 16'hFFFF.
